// File: rtl/count_bcd_conv.sv
// count_bcd_conv: sequential binary-to-BCD converter (shift-and-add-3, one
// bit per clock) that turns the counter value into packed decimal digits for
// the seven-segment driver. Results are published atomically on completion,
// so the display never sees a partially converted value.
//
// Optional feature: define COUNT_BCD_BLANK_EN to build the registered
// leading-zero blanking mask; without it `blank` is tied to all-zeros.
module count_bcd_conv #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [WIDTH-1:0] shift_q;
  logic [BW-1:0]    scratch_q;
  logic [CW-1:0]    cnt_q;
  logic [BW-1:0]    bcd_q;

  logic             accept;
  logic             last_shift;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    scratch_nxt;

  // A new conversion is accepted only when no conversion is running.
  assign accept     = start && (state == IDLE || state == DONE);
  // The shift that consumes the final input bit also publishes the result.
  assign last_shift = (state == SHIFT) && (cnt_q == CW'(1));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // Add-3 correction on every digit >= 5, then shift the next input bit in.
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      else                             adj[4*i +: 4] = scratch_q[4*i +: 4];
    end
    // The top bit of the corrected scratch is always zero for legal inputs.
    scratch_nxt = BW'({adj, shift_q[WIDTH-1]});
  end

  // Conversion datapath and published result.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
    end else begin
      if (accept) begin
        shift_q   <= bin;
        scratch_q <= '0;
        cnt_q     <= CW'(WIDTH);
      end else if (state == SHIFT) begin
        shift_q   <= {shift_q[WIDTH-2:0], 1'b0};
        scratch_q <= scratch_nxt;
        cnt_q     <= cnt_q - CW'(1);
      end
      if (last_shift) bcd_q <= scratch_nxt;
    end
  end

  assign bcd = bcd_q;

`ifdef COUNT_BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blank_nxt;
  logic              upper_zero;

  // Digit i is blanked when it and every higher digit of the new result are zero.
  always_comb begin
    blank_nxt  = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero   = upper_zero && (scratch_nxt[4*i +: 4] == 4'd0);
      blank_nxt[i] = upper_zero;
    end
  end

  // Blanking mask register, updated on the same edge as the result.
  always_ff @(posedge clk) begin
    if (rst)             blank_q <= BLANK_RST;
    else if (last_shift) blank_q <= blank_nxt;
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_count_bcd_conv.sv
// tb_count_bcd_conv: self-checking bench for count_bcd_conv. Expected digits
// and blanking masks come from decimal arithmetic on the input value.
module tb_count_bcd_conv;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

`ifdef COUNT_BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = 3'b110;
`else
  localparam logic [DIGITS-1:0] BLANK_RST = 3'b000;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [WIDTH-1:0]    bin;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   blank;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  count_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .blank (blank)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digit i is (v / 10^i) mod 10.
  function automatic logic [4*DIGITS-1:0] bcd_of(input int v);
    logic [4*DIGITS-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Reference: digit i and above are all zero exactly when v < 10^i.
  function automatic logic [DIGITS-1:0] blank_of(input int v);
    logic [DIGITS-1:0] r;
    int p;
    r = '0;
    p = 10;
    for (int i = 1; i < DIGITS; i++) begin
`ifdef COUNT_BCD_BLANK_EN
      r[i] = (v < p);
`endif
      p = p * 10;
    end
    return r;
  endfunction

  // Present a one-cycle start; returns at the negedge after the accepting edge.
  task automatic start_conv(input int v);
    @(negedge clk);
    bin   = WIDTH'(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count remaining busy cycles, then check the published result.
  task automatic finish_conv(input string tag, input int v, input int already);
    int n;
    n = already;
    while (busy && n < 4 * WIDTH) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_lat"},   n, WIDTH);
    check({tag, "_done"},  done, 1);
    check({tag, "_excl"},  busy, 0);
    check({tag, "_bcd"},   bcd, bcd_of(v));
    check({tag, "_blank"}, blank, blank_of(v));
  endtask

  initial begin
    int exp_seq[3];
    int idx;
    int guard;
    int last;
    int n_done;

    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_bcd",   bcd, 0);
    check("rst_blank", blank, BLANK_RST);
    rst = 1'b0;

    // Full-scale input.
    start_conv(255);
    finish_conv("c255", 255, 0);

    // Zero and a two-digit value exercise the blanking mask.
    start_conv(0);
    finish_conv("c0", 0, 0);
    start_conv(42);
    finish_conv("c42", 42, 0);

    // A start pulse during the conversion is ignored.
    start_conv(100);
    @(negedge clk);
    @(negedge clk);
    bin   = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_conv("ign", 100, 3);

    // Back-to-back conversions with start held high.
    exp_seq = '{9, 10, 11};
    @(negedge clk);
    @(negedge clk);
    bin   = 8'd9;
    start = 1'b1;
    idx   = 0;
    guard = 0;
    last  = 0;
    while (idx < 3 && guard < 60) begin
      @(negedge clk);
      guard++;
      if (done) begin
        check("b2b_bcd", bcd, bcd_of(exp_seq[idx]));
        if (idx > 0) check("b2b_gap", cyc - last, WIDTH + 1);
        last = cyc;
        idx++;
        if (idx < 3) bin = WIDTH'(exp_seq[idx]);
        else         start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_count", idx, 3);

    // Reset in the middle of a conversion discards it.
    start_conv(255);
    finish_conv("pre", 255, 0);
    start_conv(200);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_bcd",   bcd, 0);
    check("mid_busy",  busy, 0);
    check("mid_done",  done, 0);
    check("mid_blank", blank, BLANK_RST);
    n_done = 0;
    repeat (2 * WIDTH) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("mid_quiet", n_done, 0);

    // Randomized values against the decimal reference.
    repeat (24) begin
      int v;
      v = int'($urandom_range(0, (1 << WIDTH) - 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_conv(v);
      finish_conv("rand", v, 0);
    end

    // Reset and start together: reset wins, nothing is accepted.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    bin   = 8'd55;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rs_busy", busy, 0);
    check("rs_done", done, 0);
    @(negedge clk);
    check("rs_idle", busy, 0);
    repeat (WIDTH + 2) @(negedge clk);
    check("rs_bcd",  bcd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
